// File: rtl/hp_norm_pipe_pkg.sv
// Shared constants and transaction types for the half-precision normaliser.
// The typedefs describe operands at the default half-precision widths.
package hp_pkg;

    localparam int HP_MANT_W = 11;
    localparam int HP_NRB    = 8;
    localparam int HP_EXP_W  = 5;
    localparam int HP_IN_W   = HP_MANT_W + HP_NRB + 3;
    localparam int HP_OUT_W  = HP_MANT_W + HP_NRB;

    localparam logic [31:0] LFSR_MASK         = 32'h8020_0003;
    localparam logic [31:0] LFSR_DEFAULT_SEED = 32'hACE1_0001;

    typedef struct packed {
        logic                sign;
        logic [HP_EXP_W-1:0] exp;
        logic [HP_IN_W-1:0]  mant;
        logic                stochastic;
    } raw_op_t;

    typedef struct packed {
        logic                sign;
        logic [HP_EXP_W:0]   exp;
        logic [HP_OUT_W-1:0] mant;
        logic [HP_NRB-1:0]   rnd;
        logic                stochastic;
        logic                zero;
    } norm_op_t;

    // One step of the right-shifting Galois LFSR for x^32+x^22+x^2+x+1.
    function automatic logic [31:0] lfsr_next(input logic [31:0] state);
        return {1'b0, state[31:1]} ^ (state[0] ? LFSR_MASK : 32'h0);
    endfunction

endpackage

// File: rtl/hp_norm_pipe_if.sv
// Operand and result handshake bundle for hp_norm_pipe.
// slave is the normaliser's view, master is the view of whoever drives it.
interface hp_norm_pipe_if
    import hp_pkg::*;
#(
    parameter int MANT_W         = HP_MANT_W,
    parameter int NUM_ROUND_BITS = HP_NRB,
    parameter int EXP_W          = HP_EXP_W,
    parameter int IN_W           = MANT_W + NUM_ROUND_BITS + 3
) ();

    logic                             in_valid;
    logic                             in_ready;
    logic                             in_sign;
    logic [EXP_W-1:0]                 in_exp;
    logic [IN_W-1:0]                  in_mant;
    logic                             in_stochastic;
    logic                             seed_load;
    logic [31:0]                      seed_val;
    logic                             out_valid;
    logic                             out_ready;
    logic                             out_sign;
    logic [EXP_W:0]                   out_exp;
    logic [MANT_W+NUM_ROUND_BITS-1:0] out_mant;
    logic [NUM_ROUND_BITS-1:0]        out_rand;
    logic                             out_stochastic;
    logic                             out_zero;

    modport slave (
        input  in_valid, in_sign, in_exp, in_mant, in_stochastic,
               seed_load, seed_val, out_ready,
        output in_ready, out_valid, out_sign, out_exp, out_mant,
               out_rand, out_stochastic, out_zero
    );

    modport master (
        output in_valid, in_sign, in_exp, in_mant, in_stochastic,
               seed_load, seed_val, out_ready,
        input  in_ready, out_valid, out_sign, out_exp, out_mant,
               out_rand, out_stochastic, out_zero
    );

endinterface

// File: rtl/hp_norm_pipe_lzc.sv
// Combinational leading-zero counter; an all-zero input counts as W.
module hp_lzc #(
    parameter int W     = 22,
    parameter int CNT_W = $clog2(W + 1)
) (
    input  logic [W-1:0]     value,
    output logic [CNT_W-1:0] count
);

    // Scan upward so the most significant set bit is the last to write the count.
    always_comb begin
        count = CNT_W'(W);
        for (int i = 0; i < W; i++) begin
            if (value[i]) begin
                count = CNT_W'(W - 1 - i);
            end
        end
    end

endmodule

// File: rtl/hp_norm_pipe.sv
// Two-stage normaliser feeding the half-precision rounder.
// Stage 1 registers the raw operand with its leading-zero count; stage 2
// shifts, folds the sticky bit, adjusts the exponent and draws LFSR bits.
module hp_norm_pipe
    import hp_pkg::*;
#(
    parameter int          MANT_W         = HP_MANT_W,
    parameter int          NUM_ROUND_BITS = HP_NRB,
    parameter int          EXP_W          = HP_EXP_W,
    parameter int          IN_W           = MANT_W + NUM_ROUND_BITS + 3,
    parameter logic [31:0] LFSR_SEED      = LFSR_DEFAULT_SEED
) (
    input logic           clk,
    input logic           rst,
    hp_norm_pipe_if.slave bus
);

    localparam int OUT_W = MANT_W + NUM_ROUND_BITS;
    localparam int LZ_W  = $clog2(IN_W + 1);
    localparam int XW    = EXP_W + 1;
    localparam int CMP_W = ((LZ_W > EXP_W) ? LZ_W : EXP_W) + 1;

    logic                      in_ready;
    logic                      s2_accept;
    logic                      s2_load;
    logic [LZ_W-1:0]           in_lz;

    logic                      s1_valid;
    logic                      s1_sign;
    logic                      s1_stochastic;
    logic [EXP_W-1:0]          s1_exp;
    logic [IN_W-1:0]           s1_mant;
    logic [LZ_W-1:0]           s1_lz;

    logic                      s2_valid;
    logic                      s2_sign;
    logic                      s2_stochastic;
    logic                      s2_zero;
    logic [XW-1:0]             s2_exp;
    logic [OUT_W-1:0]          s2_mant;
    logic [NUM_ROUND_BITS-1:0] s2_rand;

    logic [31:0]               lfsr;

    logic [LZ_W-1:0]           shift;
    logic [IN_W-1:0]           norm;
    logic [OUT_W-1:0]          nxt_mant;
    logic [XW-1:0]             nxt_exp;
    logic                      nxt_zero;

    // The guard bit just below the mantissa field is dropped; only the two
    // lowest bits of the shifted value feed the sticky.
    logic                      unused_guard_bit;

    assign s2_accept = !s2_valid || bus.out_ready;
    assign in_ready  = !s1_valid || s2_accept;
    assign s2_load   = s1_valid && s2_accept;

    hp_lzc #(
        .W     (IN_W),
        .CNT_W (LZ_W)
    ) u_lzc (
        .value (bus.in_mant),
        .count (in_lz)
    );

    // Stage 1 takes a new operand whenever it is empty or draining into stage 2.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid      <= 1'b0;
            s1_sign       <= 1'b0;
            s1_stochastic <= 1'b0;
            s1_exp        <= '0;
            s1_mant       <= '0;
            s1_lz         <= '0;
        end else if (in_ready) begin
            s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                s1_sign       <= bus.in_sign;
                s1_stochastic <= bus.in_stochastic;
                s1_exp        <= bus.in_exp;
                s1_mant       <= bus.in_mant;
                s1_lz         <= in_lz;
            end
        end
    end

    // Normalise: shift by the smaller of lz and exponent so denormals stay put.
    always_comb begin
        nxt_zero = (s1_lz == LZ_W'(IN_W));
        if (CMP_W'(s1_lz) < CMP_W'(s1_exp)) begin
            shift = s1_lz;
        end else begin
            shift = LZ_W'(s1_exp);
        end
        norm        = s1_mant << shift;
        nxt_mant    = norm[IN_W-1 -: OUT_W];
        nxt_mant[0] = nxt_mant[0] | (|norm[1:0]);
        nxt_exp     = {1'b0, s1_exp} + XW'(1) - XW'(shift);
        if (!norm[IN_W-1]) begin
            nxt_exp = '0;
        end
        if (nxt_zero) begin
            nxt_mant = '0;
            nxt_exp  = '0;
        end
    end

    assign unused_guard_bit = norm[IN_W-OUT_W-1];

    // Output register: loads when stage 2 is free and holds still under backpressure.
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid      <= 1'b0;
            s2_sign       <= 1'b0;
            s2_stochastic <= 1'b0;
            s2_zero       <= 1'b0;
            s2_exp        <= '0;
            s2_mant       <= '0;
            s2_rand       <= '0;
        end else if (s2_accept) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_sign       <= s1_sign;
                s2_stochastic <= s1_stochastic;
                s2_zero       <= nxt_zero;
                s2_exp        <= nxt_exp;
                s2_mant       <= nxt_mant;
                s2_rand       <= lfsr[NUM_ROUND_BITS-1:0];
            end
        end
    end

    // Random source: one step per stage-2 load, a seed load takes priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr <= LFSR_SEED;
        end else if (bus.seed_load) begin
            lfsr <= (bus.seed_val == 32'h0) ? 32'h1 : bus.seed_val;
        end else if (s2_load) begin
            lfsr <= lfsr_next(lfsr);
        end
    end

    assign bus.in_ready       = in_ready;
    assign bus.out_valid      = s2_valid;
    assign bus.out_sign       = s2_sign;
    assign bus.out_exp        = s2_exp;
    assign bus.out_mant       = s2_mant;
    assign bus.out_rand       = s2_rand;
    assign bus.out_stochastic = s2_stochastic;
    assign bus.out_zero       = s2_zero;

endmodule
